// File: rtl/eth_tx_frame_gen.sv
// eth_tx_frame_gen
//   Ethernet II test-frame source for the 10G MAC TX AXI-Stream (64-bit beats).
//   Each frame: dst_mac, src_mac, ethertype, a 32-bit big-endian sequence number
//   (frames_sent at the frame's first beat), then a byte ramp. The payload length
//   is clamped to [MIN_PAYLOAD, MAX_PAYLOAD]. The FCS is left to the MAC.
//
//   Ports
//     clk_125mhz_int, gt_tx_reset (async, active-high)
//     start / stop              : run control pulses
//     frame_count               : frames per run, 0 = until stop
//     payload_len               : requested payload bytes (clamped)
//     dst_mac, src_mac, ethertype: header fields, MSB byte first on the wire
//     m_axis_*                  : AXI-Stream master, byte n in tdata[8n+7:8n]
//     busy, frames_sent         : status
//
//   Optional build macro ETH_TX_FRAME_GEN_BAD_FRAME_EN adds input inject_err,
//   sampled on entry to HDR0, which raises tuser on that frame's last beat.
module eth_tx_frame_gen #(
  parameter int GAP_CYCLES  = 4,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clk_125mhz_int,
  input  logic        gt_tx_reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_count,
  input  logic [13:0] payload_len,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
`ifdef ETH_TX_FRAME_GEN_BAD_FRAME_EN
  input  logic        inject_err,
`endif
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic [31:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, GAP} state_t;

  localparam logic [15:0] MIN_P  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_P  = 16'(MAX_PAYLOAD);
  // GAP covers all but the last idle cycle; the HDR0 cycle that builds the
  // next first beat is the final tvalid-low cycle.
  localparam logic [15:0] GAP_M1 = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t      state_q, state_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic [31:0] frames_sent_q, frames_sent_d, seq_q, seq_d;
  logic [15:0] run_cnt_q, run_cnt_d, frame_cnt_q, frame_cnt_d;
  logic [15:0] frame_len_q, frame_len_d, byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] eth_q, eth_d;
  logic        stop_pend_q, stop_pend_d;
  logic        err_q;

  logic [15:0] req_len, clamp_p, bi;
  logic [63:0] beat_data;
  logic [7:0]  beat_keep;
  logic        beat_last, load, hs, out_free, run_done, end_run;

  function automatic logic [7:0] frame_byte(input logic [15:0] b, input logic [47:0] d,
                                            input logic [47:0] s, input logic [15:0] e,
                                            input logic [31:0] q);
    logic [7:0] v;
    if (b < 16'd6)       v = d[8*(5 - int'(b)) +: 8];
    else if (b < 16'd12) v = s[8*(11 - int'(b)) +: 8];
    else if (b < 16'd14) v = e[8*(13 - int'(b)) +: 8];
    else if (b < 16'd18) v = q[8*(17 - int'(b)) +: 8];
    else                 v = 8'(b - 16'd14);  // ramp restarts its count at byte 14
    return v;
  endfunction

  assign req_len = {2'b00, payload_len};
  always_comb begin
    clamp_p = req_len;
    if (req_len < MIN_P)      clamp_p = MIN_P;
    else if (req_len > MAX_P) clamp_p = MAX_P;
  end

  // Beat starting at byte_cnt_q; bytes past the frame end are zeroed and unkept.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    bi        = '0;
    for (int i = 0; i < 8; i++) begin
      bi           = byte_cnt_q + 16'(i);
      beat_keep[i] = bi < frame_len_q;
      if (beat_keep[i]) beat_data[8*i +: 8] = frame_byte(bi, dst_q, src_q, eth_q, seq_q);
    end
    beat_last = (byte_cnt_q + 16'd8) >= frame_len_q;
  end

  assign hs       = tvalid_q & m_axis_tready;
  assign out_free = ~tvalid_q | m_axis_tready;

  always_comb begin
    state_d       = state_q;
    tdata_d       = tdata_q;
    tkeep_d       = tkeep_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    frames_sent_d = frames_sent_q;
    seq_d         = seq_q;
    run_cnt_d     = run_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frame_len_d   = frame_len_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    dst_d         = dst_q;
    src_d         = src_q;
    eth_d         = eth_q;
    load          = 1'b0;

    if (hs && tlast_q) begin
      frames_sent_d = frames_sent_q + 32'd1;
      run_cnt_d     = run_cnt_q + 16'd1;
    end
    run_done    = (frame_cnt_q != 16'd0) && (run_cnt_d == frame_cnt_q);
    end_run     = run_done | stop_pend_q | stop;
    stop_pend_d = (state_q != IDLE) && (stop_pend_q || stop);

    case (state_q)
      IDLE: if (start) begin
        frame_cnt_d = frame_count;
        frame_len_d = clamp_p + 16'd14;
        dst_d       = dst_mac;
        src_d       = src_mac;
        eth_d       = ethertype;
        run_cnt_d   = '0;
        state_d     = HDR0;
      end
      // tvalid_q here only when GAP_CYCLES == 0: the previous tlast is still
      // pending and the continue/stop decision rides on its handshake.
      HDR0: if (out_free) begin
        if (tvalid_q && end_run) state_d = IDLE;
        else begin
          load    = 1'b1;
          seq_d   = frames_sent_d;
          state_d = HDR1;
        end
      end
      HDR1: if (out_free) begin
        load    = 1'b1;
        state_d = PAYLOAD;
      end
      PAYLOAD: if (out_free) begin
        load = 1'b1;
        if (beat_last) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? HDR0 : GAP;
        end
      end
      GAP: begin
        if (tvalid_q) begin
          if (m_axis_tready && GAP_M1 == 16'd0) state_d = end_run ? IDLE : HDR0;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
          if (gap_cnt_d >= GAP_M1) state_d = end_run ? IDLE : HDR0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tdata_d    = beat_data;
      tkeep_d    = beat_keep;
      tlast_d    = beat_last;
      tuser_d    = beat_last & err_q;
      tvalid_d   = 1'b1;
      byte_cnt_d = byte_cnt_q + 16'd8;
    end else if (hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
    if (state_d == HDR0 && state_q != HDR0) byte_cnt_d = '0;
  end

`ifdef ETH_TX_FRAME_GEN_BAD_FRAME_EN
  logic err_d;
  always_comb begin
    err_d = err_q;
    if (state_d == HDR0 && state_q != HDR0) err_d = inject_err;
  end
  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) err_q <= 1'b0;
    else             err_q <= err_d;
  end
`else
  assign err_q = 1'b0;
`endif

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state_q       <= IDLE;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frames_sent_q <= '0;
      seq_q         <= '0;
      run_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      frame_len_q   <= '0;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      eth_q         <= '0;
      stop_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      frames_sent_q <= frames_sent_d;
      seq_q         <= seq_d;
      run_cnt_q     <= run_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_len_q   <= frame_len_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      eth_q         <= eth_d;
      stop_pend_q   <= stop_pend_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q != IDLE);
  assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Directed bench for eth_tx_frame_gen (default build, GAP_CYCLES = 4).
// A negedge monitor collects handshaked beats into per-frame byte records.
module tb_eth_tx_frame_gen;
  logic        clk_125mhz_int = 1'b0;
  logic        gt_tx_reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] frame_count = '0;
  logic [13:0] payload_len = '0;
  logic [47:0] dst_mac = '0, src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy;
  logic        m_axis_tready = 1'b1;
  logic [31:0] frames_sent;

  always #4 clk_125mhz_int = ~clk_125mhz_int;

  eth_tx_frame_gen dut (
    .clk_125mhz_int(clk_125mhz_int), .gt_tx_reset(gt_tx_reset),
    .start(start), .stop(stop), .frame_count(frame_count), .payload_len(payload_len),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frames_sent(frames_sent)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- ready driver ----------------
  bit rand_rdy = 0;
  initial forever begin
    @(posedge clk_125mhz_int);
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  logic [7:0] fr_data [0:23][0:1599];
  int         fr_len [24];
  int         fr_beats [24];
  int         fr_gap [24];
  logic [7:0] fr_lastkeep [24];
  int  nfr = 0, cur_n = 0, cur_beats = 0, low_cnt = 0;
  bit  in_frame = 0, stalled = 0;
  logic [73:0] stall_snap = '0;
  int  stall_err = 0, drop_err = 0, keep_err = 0, user_err = 0;

  initial forever begin
    @(negedge clk_125mhz_int);
    if (gt_tx_reset) begin
      cur_n = 0; cur_beats = 0; in_frame = 0; stalled = 0; low_cnt = 0;
    end else begin
      if (stalled && (!m_axis_tvalid ||
          {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} != stall_snap)) stall_err++;
      if (in_frame && !m_axis_tvalid) drop_err++;
      if (!m_axis_tvalid) low_cnt++;
      stalled    = m_axis_tvalid && !m_axis_tready;
      stall_snap = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      if (m_axis_tvalid && m_axis_tready && nfr < 24) begin
        if (cur_beats == 0) fr_gap[nfr] = low_cnt;
        cur_beats++;
        if (m_axis_tuser) user_err++;
        if (!m_axis_tlast && m_axis_tkeep != 8'hFF) keep_err++;
        for (int i = 0; i < 8; i++)
          if (m_axis_tkeep[i] && cur_n < 1600) begin
            fr_data[nfr][cur_n] = m_axis_tdata[8*i +: 8];
            cur_n++;
          end
        in_frame = !m_axis_tlast;
        if (m_axis_tlast) begin
          fr_len[nfr] = cur_n; fr_beats[nfr] = cur_beats; fr_lastkeep[nfr] = m_axis_tkeep;
          nfr++; cur_n = 0; cur_beats = 0; low_cnt = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] exp_byte(input int b, input logic [47:0] d, input logic [47:0] s,
                                          input logic [15:0] e, input logic [31:0] q);
    if (b < 6)  return d[8*(5 - b) +: 8];
    if (b < 12) return s[8*(11 - b) +: 8];
    if (b < 14) return e[8*(13 - b) +: 8];
    if (b < 18) return q[8*(17 - b) +: 8];
    return 8'(b - 14);
  endfunction

  task automatic tick();
    @(negedge clk_125mhz_int);
    #1;
  endtask

  task automatic run(input logic [15:0] fc, input logic [13:0] pl, input logic [47:0] d,
                     input logic [47:0] s, input logic [15:0] e);
    frame_count = fc; payload_len = pl; dst_mac = d; src_mac = s; ethertype = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    // config must have been captured on the accepted start
    frame_count = 16'h0007; payload_len = 14'h3FFF; dst_mac = '1; src_mac = '1; ethertype = '1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int fi, input int e_len, input int e_beats,
                             input logic [7:0] e_keep, input logic [31:0] seq,
                             input logic [47:0] d, input logic [47:0] s, input logic [15:0] e);
    int mism = 0;
    check({tag, ".len"}, fr_len[fi], e_len);
    check({tag, ".beats"}, fr_beats[fi], e_beats);
    check({tag, ".lastkeep"}, fr_lastkeep[fi], e_keep);
    check({tag, ".seq"}, {fr_data[fi][14], fr_data[fi][15], fr_data[fi][16], fr_data[fi][17]}, seq);
    for (int b = 0; b < e_len && b < 1600; b++)
      if (fr_data[fi][b] !== exp_byte(b, d, s, e, seq)) mism++;
    check({tag, ".bytes"}, mism, 0);
  endtask

  task automatic do_reset();
    gt_tx_reset = 1'b1;
    repeat (2) tick();
    gt_tx_reset = 1'b0;
    tick();
  endtask

  localparam logic [47:0] D1 = 48'h02_11_22_33_44_55;
  localparam logic [47:0] S1 = 48'h0A_BB_CC_DD_EE_FF;
  localparam logic [15:0] E1 = 16'h88B5;

  int          base, k;
  logic [31:0] exp_fs;
  int          cl_pl   [3] = '{10, 50, 4000};
  int          cl_len  [3] = '{60, 64, 1514};
  int          cl_beats[3] = '{8, 8, 190};
  logic [7:0]  cl_keep [3] = '{8'h0F, 8'hFF, 8'h03};

  initial begin
    // reset state
    repeat (3) tick();
    check("rst.tvalid", m_axis_tvalid, 0);
    check("rst.tlast", m_axis_tlast, 0);
    check("rst.tuser", m_axis_tuser, 0);
    check("rst.tkeep", m_axis_tkeep, 0);
    check("rst.tdata", m_axis_tdata, 0);
    check("rst.busy", busy, 0);
    check("rst.fs", frames_sent, 0);
    gt_tx_reset = 1'b0;
    tick();

    // minimum frame, plus first-beat latency
    base = nfr;
    run(1, 46, D1, S1, E1);
    check("min.busy", busy, 1);
    check("min.hdr0_novalid", m_axis_tvalid, 0);
    tick();
    check("min.b0_valid", m_axis_tvalid, 1);
    check("min.b0_keep", m_axis_tkeep, 8'hFF);
    check("min.b0_byte0", m_axis_tdata[7:0], 8'h02);
    wait_idle(60, "min");
    check_frame("min", base, 60, 8, 8'h0F, 0, D1, S1, E1);
    check("min.fs", frames_sent, 1);
    exp_fs = 1;

    // clamp / boundary lengths
    for (int i = 0; i < 3; i++) begin
      base = nfr;
      run(1, 14'(cl_pl[i]), D1 ^ 48'(i), S1, E1 + 16'(i));
      wait_idle(400, "clamp");
      check_frame($sformatf("clamp%0d", cl_pl[i]), base, cl_len[i], cl_beats[i], cl_keep[i],
                  exp_fs, D1 ^ 48'(i), S1, E1 + 16'(i));
      exp_fs++;
      check("clamp.fs", frames_sent, exp_fs);
    end

    // backpressure
    base = nfr;
    rand_rdy = 1;
    run(1, 100, 48'hFFEEDDCCBBAA, 48'h112233445566, 16'h0800);
    wait_idle(1000, "bp");
    rand_rdy = 0;
    tick();
    check_frame("bp", base, 114, 15, 8'h03, exp_fs, 48'hFFEEDDCCBBAA, 48'h112233445566, 16'h0800);
    check("bp.stall_stable", stall_err, 0);
    check("bp.no_drop", drop_err, 0);

    // run count and inter-frame gap; a start mid-run is ignored
    do_reset();
    base = nfr;
    run(3, 46, D1, S1, E1);
    repeat (5) tick();
    payload_len = 14'd200; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300, "run3");
    check("run3.frames", nfr - base, 3);
    for (int i = 0; i < 3; i++)
      check_frame($sformatf("run3.f%0d", i), base + i, 60, 8, 8'h0F, 32'(i), D1, S1, E1);
    check("run3.gap1", fr_gap[base + 1], 4);
    check("run3.gap2", fr_gap[base + 2], 4);
    check("run3.fs", frames_sent, 3);

    // continuous run, stop during frame 5
    do_reset();
    base = nfr;
    run(0, 46, S1, D1, 16'h86DD);
    k = 0;
    while (!((nfr - base) == 5 && cur_beats >= 2) && k < 2000) begin tick(); k++; end
    check("cont.reach_f5", (nfr - base) == 5, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(200, "cont");
    check("cont.frames", nfr - base, 6);
    check("cont.fs", frames_sent, 6);
    check_frame("cont.f5", base + 5, 60, 8, 8'h0F, 5, S1, D1, 16'h86DD);
    repeat (20) tick();
    check("cont.no_f6", nfr - base, 6);

    // reset in the middle of a frame
    base = nfr;
    run(1, 46, D1, S1, E1);
    k = 0;
    while (cur_beats != 3 && k < 100) begin tick(); k++; end
    check("rstmid.at_beat3", cur_beats, 3);
    gt_tx_reset = 1'b1;
    #1;
    check("rstmid.tvalid", m_axis_tvalid, 0);
    check("rstmid.fs", frames_sent, 0);
    check("rstmid.busy", busy, 0);
    repeat (2) tick();
    gt_tx_reset = 1'b0;
    tick();
    check("rstmid.no_frame", nfr - base, 0);
    run(1, 46, D1, S1, E1);
    wait_idle(60, "rstmid");
    check_frame("rstmid.new", base, 60, 8, 8'h0F, 0, D1, S1, E1);
    check("rstmid.fs1", frames_sent, 1);

    // whole-run invariants
    check("all.keep_ff_midframe", keep_err, 0);
    check("all.tuser_zero", user_err, 0);
    check("all.stall_stable", stall_err, 0);
    check("all.no_drop", drop_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/eth_tx_frame_gen.md
Name: eth_tx_frame_gen

Overview:
- Test-traffic source feeding the 10G MAC TX AXI-Stream (64-bit, tkeep, tlast, tuser) in the 125 MHz domain.
- Output goes through the existing async AXIS FIFO into the MAC's eth0_tx_axis port on the GT TX user clock.
- Emits Ethernet II frames: programmable MAC addresses, ethertype and payload length; a 32-bit sequence number; then a byte-ramp payload.
- Used for link bring-up and loopback/BER soak on the Alveo QSFP port.

Parameters:
- GAP_CYCLES, 4, idle cycles (tvalid low) inserted between consecutive frames; 0 allowed (back-to-back).
- MIN_PAYLOAD, 46, lower clamp on payload bytes.
- MAX_PAYLOAD, 1500, upper clamp on payload bytes.

Ports:
- clk_125mhz_int  in  1  clock.
- gt_tx_reset  in  1  reset: asynchronous, active-high.
- start  in  1  single-cycle pulse; starts a run when idle.
- stop  in  1  pulse; ends the run after the current frame.
- frame_count  in  16  frames per run; 0 = run until stop.
- payload_len  in  14  requested payload bytes; clamped.
- dst_mac  in  48  destination MAC; [47:40] is the first byte on the wire.
- src_mac  in  48  source MAC, same byte order.
- ethertype  in  16  EtherType, [15:8] sent first.
- m_axis_tdata  out  64  byte n of the beat in [8n+7:8n].
- m_axis_tkeep  out  8  byte enables.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  error/abort flag to MAC.
- busy  out  1  high while state != IDLE.
- frames_sent  out  32  completed frames, wraps at 2^32.

Behaviour:
- Reset: gt_tx_reset is asynchronous, active-high; clock is clk_125mhz_int.
  - Reset forces: state IDLE, tvalid 0, tlast 0, tuser 0, tkeep 0, tdata 0, busy 0, frames_sent 0, run counter 0.
  - Reset mid-frame truncates the frame immediately, with no tlast. The downstream frame FIFO discards the partial frame.
- State machine: IDLE -> HDR0 -> HDR1 -> PAYLOAD -> GAP -> (HDR0 | IDLE).
  - IDLE: start latches frame_count, dst_mac, src_mac, ethertype and the clamped payload P, then -> HDR0 on the next cycle. start outside IDLE is ignored.
  - Config inputs are sampled only on the accepted start.
- Clamping: P = max(MIN_PAYLOAD, min(MAX_PAYLOAD, payload_len)).
  - Frame length L = 14 + P bytes, FCS excluded (the MAC appends it).
  - Beats = ceil(L/8).
- Frame byte map:
  - Bytes 0-5: dst_mac.
  - Bytes 6-11: src_mac.
  - Bytes 12-13: ethertype.
  - Bytes 14-17: seq, big-endian; seq = frames_sent at the first beat of the frame.
  - Byte 14+k for k>=4: k[7:0].
- HDR0 carries bytes 0-7; HDR1 carries bytes 8-15; PAYLOAD carries the remaining beats. A 16-bit byte counter tracks position.
- tkeep: 0xFF on all beats except the last.
  - Last beat: tkeep = (1 << r) - 1 where r = L mod 8; r = 0 gives 0xFF.
  - tlast is asserted only on the last beat.
- Handshake: a beat transfers when tvalid & tready.
  - While tvalid & !tready, tdata, tkeep, tlast and tuser hold stable.
  - tvalid never drops mid-frame except on reset.
  - Registered outputs: the first beat appears the cycle after entering HDR0. Zero bubbles inside a frame when tready stays high.
- Completion: frames_sent increments on the tlast handshake, wrapping 0xFFFFFFFF -> 0.
- GAP: tvalid low for exactly GAP_CYCLES cycles, then:
  - -> IDLE if stop is pending, or if the run count is reached (frame_count != 0);
  - otherwise -> HDR0.
  - With GAP_CYCLES = 0, the next HDR0 beat follows tlast directly.
- stop: latched as pending in any non-IDLE state; never truncates a frame.
  - stop and start in the same IDLE cycle: start wins, stop is ignored.
  - stop arriving on the tlast cycle ends the run after that frame.
- busy: falls in the cycle the state returns to IDLE.

Optional Feature:
- Macro: ETH_TX_FRAME_GEN_BAD_FRAME_EN.
- When defined:
  - Extra input inject_err (1 bit), sampled at each frame's HDR0 entry.
  - If set, m_axis_tuser = 1 on that frame's last beat, so the MAC corrupts the FCS (frame counted as bad at the far end).
  - tuser is 0 on all other beats.
- When undefined:
  - No inject_err port.
  - m_axis_tuser is constant 0.

Test Plan:
- Min frame: start, payload_len=46, frame_count=1, tready=1 -> 8 beats; beat 7 tkeep=0x0F, tlast=1; bytes 14-17 = 00 00 00 00; frames_sent=1; busy falls.
- Clamp/boundary: payload_len=10 -> identical to 46 (8 beats, tkeep 0x0F). payload_len=50 -> L=64, 8 beats, last tkeep=0xFF. payload_len=4000 -> L=1514, 190 beats, last tkeep=0x03.
- Backpressure: random tready (~50%) on a 100-byte payload -> tdata/tkeep/tlast stable while stalled; byte stream matches the reference model; no tvalid drop.
- Run count and gap: frame_count=3, GAP_CYCLES=4 -> 3 frames, seq 0,1,2; exactly 4 tvalid-low cycles between frames; frames_sent=3; return to IDLE.
- Continuous + stop: frame_count=0, stop pulsed mid-frame 5 -> frame 5 completes with tlast; no frame 6; frames_sent=6.
- Reset mid-frame: gt_tx_reset asserted on beat 3 -> tvalid=0 in the same cycle (async); frames_sent=0. A new start after release begins at HDR0 with seq=0.
